// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : sync_fifo_pkg                                          |
// | Description : Sizing helpers, pointer wrap and flag-level defaults    |
// |               shared by the synchronous FIFO.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sync_fifo_pkg;

    localparam int unsigned AE_LEVEL_DFLT = 1;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned af_level_dflt(input int unsigned depth);
        return depth - 1;
    endfunction

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_ram                                          |
// | Description : Single-clock storage, one write port, one async read.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_gen                                          |
// | Description : Synchronous FIFO with occupancy count, status flags    |
// |               and overflow/underflow pulses. Define                  |
// |               SYNC_FIFO_FWFT_EN for first-word-fall-through output.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_gen
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = af_level_dflt(DEPTH),
    parameter int unsigned AE_LEVEL   = AE_LEVEL_DFLT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        r_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign almost_empty = (32'(count_q) <= AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= w_en && full;
            underflow_q <= r_en && empty;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown combinationally; reset clears count so output reads 0.
    assign data_out = empty ? '0 : rdata;
`else
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= rdata;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sync_fifo_gen                                       |
// | Description : Scoreboard bench for sync_fifo_gen at DEPTH 8 and 5.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sync_fifo_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       w8, r8, full8, empty8, af8, ae8, ovf8, unf8;
    logic [7:0] d8, q8;
    logic [3:0] cnt8;
    logic       w5, r5, full5, empty5, af5, ae5, ovf5, unf5;
    logic [7:0] d5, q5;
    logic [2:0] cnt5;

    sync_fifo_gen #(.DATA_WIDTH(8), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .w_en(w8), .data_in(d8), .r_en(r8), .data_out(q8),
        .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8),
        .count(cnt8), .overflow(ovf8), .underflow(unf8)
    );

    sync_fifo_gen #(.DATA_WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst(rst), .w_en(w5), .data_in(d5), .r_en(r5), .data_out(q5),
        .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
        .count(cnt5), .overflow(ovf5), .underflow(unf5)
    );

    logic [7:0] sb8[$];
    logic [7:0] sb5[$];
    logic [7:0] exp_dout8, exp_dout5;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the selected FIFO, then full status check.
    task automatic step(input int sel, input bit w, input bit r, input logic [7:0] d);
        int         depth, sz;
        bit         fm, em, wa, ra;
        logic [7:0] o_q, e_q;
        logic [3:0] o_cnt;
        logic       o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
        string      p;
        @(negedge clk);
        w8 = 1'b0; r8 = 1'b0; w5 = 1'b0; r5 = 1'b0;
        if (sel == 8) begin
            w8 = w; r8 = r; d8 = d; sz = sb8.size(); depth = 8;
        end else begin
            w5 = w; r5 = r; d5 = d; sz = sb5.size(); depth = 5;
        end
        fm = (sz == depth);
        em = (sz == 0);
        wa = w && !fm;
        ra = r && !em;
        if (wa) begin
            if (sel == 8) sb8.push_back(d); else sb5.push_back(d);
        end
        @(posedge clk);
        #1;
        if (sel == 8) begin
            o_q = q8; o_cnt = cnt8; o_full = full8; o_empty = empty8;
            o_af = af8; o_ae = ae8; o_ovf = ovf8; o_unf = unf8;
        end else begin
            o_q = q5; o_cnt = {1'b0, cnt5}; o_full = full5; o_empty = empty5;
            o_af = af5; o_ae = ae5; o_ovf = ovf5; o_unf = unf5;
        end
        if (ra) begin
            if (sel == 8) exp_dout8 = sb8.pop_front(); else exp_dout5 = sb5.pop_front();
        end
        sz = (sel == 8) ? sb8.size() : sb5.size();
`ifdef SYNC_FIFO_FWFT_EN
        if (sz == 0) e_q = 8'h00;
        else e_q = (sel == 8) ? sb8[0] : sb5[0];
`else
        e_q = (sel == 8) ? exp_dout8 : exp_dout5;
`endif
        p = $sformatf("d%0d_w%0d_r%0d", sel, w, r);
        check_eq({p, "_count"},    32'(o_cnt),   32'(sz));
        check_eq({p, "_full"},     32'(o_full),  32'(sz == depth));
        check_eq({p, "_empty"},    32'(o_empty), 32'(sz == 0));
        check_eq({p, "_afull"},    32'(o_af),    32'(sz >= depth - 1));
        check_eq({p, "_aempty"},   32'(o_ae),    32'(sz <= 1));
        check_eq({p, "_overflow"}, 32'(o_ovf),   32'(w && fm));
        check_eq({p, "_underflow"},32'(o_unf),   32'(r && em));
        check_eq({p, "_data_out"}, 32'(o_q),     32'(e_q));
    endtask

    // Reset with requests asserted; they must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        w8 = 1'b1; r8 = 1'b1; d8 = 8'hEE;
        w5 = 1'b1; r5 = 1'b1; d5 = 8'hEE;
        @(posedge clk);
        #1;
        check_eq("rst_d8_count", 32'(cnt8), 0);
        check_eq("rst_d8_empty", 32'(empty8), 1);
        check_eq("rst_d8_aempty", 32'(ae8), 1);
        check_eq("rst_d8_full", 32'(full8), 0);
        check_eq("rst_d8_afull", 32'(af8), 0);
        check_eq("rst_d8_data_out", 32'(q8), 0);
        check_eq("rst_d8_ovf_unf", 32'({ovf8, unf8}), 0);
        check_eq("rst_d5_count", 32'(cnt5), 0);
        check_eq("rst_d5_empty", 32'(empty5), 1);
        check_eq("rst_d5_data_out", 32'(q5), 0);
        sb8.delete();
        sb5.delete();
        exp_dout8 = 8'h00;
        exp_dout5 = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        w8 = 1'b0; r8 = 1'b0; w5 = 1'b0; r5 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        w8 = 1'b0; r8 = 1'b0; d8 = 8'h00;
        w5 = 1'b0; r5 = 1'b0; d5 = 8'h00;
        exp_dout8 = 8'h00;
        exp_dout5 = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();

        // Fill, overflow, drain, underflow.
        for (int i = 1; i <= 8; i++) step(8, 1'b1, 1'b0, 8'(i));
        step(8, 1'b1, 1'b0, 8'h99);
        step(8, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(8, 1'b0, 1'b1, 8'h00);
        step(8, 1'b0, 1'b1, 8'h00);
        step(8, 1'b0, 1'b0, 8'h00);

        // Simultaneous requests when full, then when empty.
        for (int i = 0; i < 8; i++) step(8, 1'b1, 1'b0, 8'h10 + 8'(i));
        step(8, 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 7; i++) step(8, 1'b0, 1'b1, 8'h00);
        step(8, 1'b1, 1'b1, 8'hA5);
        step(8, 1'b0, 1'b1, 8'h00);
        step(8, 1'b0, 1'b0, 8'h00);

        // Reset mid-operation discards contents.
        for (int i = 0; i < 3; i++) step(8, 1'b1, 1'b0, 8'h50 + 8'(i));
        do_reset();
        step(8, 1'b1, 1'b0, 8'h3C);
        step(8, 1'b0, 1'b1, 8'h00);

        // Pointer wrap on a non-power-of-two depth.
        for (int i = 0; i < 3; i++) step(5, 1'b1, 1'b0, 8'h21 + 8'(i));
        for (int i = 0; i < 3; i++) step(5, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(5, 1'b1, 1'b0, 8'h31 + 8'(i));
        for (int i = 0; i < 4; i++) step(5, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(5, 1'b1, 1'b0, 8'h41 + 8'(i));
        step(5, 1'b1, 1'b1, 8'h66);

        // Random traffic on both depths.
        for (int i = 0; i < 80; i++) begin
            step(8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            step(5, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
